// File: rtl/input_router_pkg.sv
// input_router_pkg: shared state encoding, precision-mode codes and sizing helper for the input-router controller
// No ports; imported by input_router_ctrl and its sub-modules.
package input_router_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FETCH  = 3'd4,
    ST_STREAM = 3'd5,
    ST_DONE   = 3'd6
  } state_e;
  localparam logic [1:0] PMODE_8B = 2'd0;
  localparam logic [1:0] PMODE_4B = 2'd1;
  localparam logic [1:0] PMODE_2B = 2'd2;
  localparam logic [1:0] PMODE_1B = 2'd3;
  function automatic int row_cnt_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction
endpackage

// File: rtl/input_router_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones instead of wrapping
// Ports:
//   i_clk, i_nrst  clock, asynchronous active-low reset
//   i_clr          clear to zero (wins over i_en)
//   i_en           count enable
//   o_cnt          current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_clr ? '0 : (i_en && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_cnt = cnt_q;
endmodule

// File: rtl/input_router_ctrl.sv
// input_router_ctrl: sequencer for one input-router row group (clear, address load, compare, MISO drain)
// Ports:
//   i_clk, i_nrst               clock, asynchronous active-low reset
//   i_start, i_abort            layer-controller start pulse and abort request
//   i_p_mode, i_num_rows        tile config, latched on an accepted start (0 rows means ROWS)
//   i_ag_valid                  address-generator response, one cycle after o_ag_en
//   i_tr_done                   tile reader finished streaming
//   i_addr_empty, i_data_empty  row-group MPP-empty and MISO-empty flags
//   i_stall                     downstream backpressure
//   o_reg_clear, o_ag_en, o_row_id, o_ac_en, o_tr_en, o_miso_pop_en  row-group / AG / TR controls
//   o_p_mode, o_busy, o_done, o_error, o_state                      status and debug
module input_router_ctrl
  import input_router_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int CNT_W      = 16,
  parameter int AG_TIMEOUT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_nrst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [1:0]                i_p_mode,
  input  logic [$clog2(ROWS+1)-1:0] i_num_rows,
  input  logic                      i_ag_valid,
  input  logic                      i_tr_done,
  input  logic                      i_addr_empty,
  input  logic                      i_data_empty,
  input  logic                      i_stall,
  output logic                      o_reg_clear,
  output logic                      o_ag_en,
  output logic [ROWS-1:0]           o_row_id,
  output logic                      o_ac_en,
  output logic                      o_tr_en,
  output logic                      o_miso_pop_en,
  output logic [1:0]                o_p_mode,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [2:0]                o_state
);
  localparam int NR_W = $clog2(ROWS+1);
  localparam int RW   = row_cnt_w(ROWS);
  state_e          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [NR_W-1:0] nr_q, nr_d;
  logic [1:0]      pmode_q, pmode_d;
  logic            err_q, err_d;
  logic            abort_q, abort_d;
  logic            trs_q, trs_d;
  logic [ROWS-1:0] row_id_q, row_id_d;
  logic            clr_q, ag_q, fetch_q, stream_q, busy_q, done_q;
  logic [CNT_W-1:0] wait_cnt, dwell_cnt;
  logic            last_row, tmo, dwell_ok;
  sat_counter #(.W(CNT_W)) u_tmo (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .i_clr (state_q != ST_WAIT),
    .i_en  (state_q == ST_WAIT),
    .o_cnt (wait_cnt)
  );
  sat_counter #(.W(CNT_W)) u_dwell (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .i_clr (state_q != ST_STREAM),
    .i_en  (state_q == ST_STREAM && !i_stall),
    .o_cnt (dwell_cnt)
  );
  assign last_row = NR_W'(r_q) == nr_q - NR_W'(1);
  // wait_cnt holds the number of WAIT cycles already spent, so this is the last allowed one
  assign tmo      = wait_cnt == CNT_W'(AG_TIMEOUT - 1);
  // dwell_cnt excludes the current cycle; ROWS prior unstalled cycles makes this the ROWS+1th,
  // enough for the staggered pop enables to reach every row
  assign dwell_ok = dwell_cnt >= CNT_W'(ROWS);
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    nr_d    = nr_q;
    pmode_d = pmode_q;
    err_d   = err_q;
    abort_d = abort_q;
    trs_d   = 1'b0;
    if (i_abort && state_q != ST_IDLE) begin
      state_d = ST_CLEAR;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (i_start && !i_abort) begin
          state_d = ST_CLEAR;
          pmode_d = i_p_mode;
          nr_d    = (i_num_rows == '0 || int'(i_num_rows) > ROWS) ? NR_W'(ROWS) : i_num_rows;
          err_d   = 1'b0;
          abort_d = 1'b0;
          r_d     = '0;
        end
        ST_CLEAR: state_d = abort_q ? ST_IDLE : ST_ISSUE;
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT: if (i_ag_valid) begin
          state_d = last_row ? ST_FETCH : ST_ISSUE;
          r_d     = last_row ? r_q : r_q + RW'(1);
        end else if (tmo) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
        ST_FETCH: begin
          // a tr_done pulse may precede addr_empty, so it is remembered while in FETCH
          trs_d   = trs_q | i_tr_done;
          state_d = (trs_d && i_addr_empty) ? ST_STREAM : ST_FETCH;
        end
        ST_STREAM: state_d = (i_data_empty && dwell_ok && !i_stall) ? ST_DONE : ST_STREAM;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
    row_id_d = (state_d == ST_ISSUE) ? ROWS'(r_d) : row_id_q;
  end
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      nr_q     <= '0;
      pmode_q  <= PMODE_8B;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      trs_q    <= 1'b0;
      row_id_q <= '0;
      clr_q    <= 1'b0;
      ag_q     <= 1'b0;
      fetch_q  <= 1'b0;
      stream_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      nr_q     <= nr_d;
      pmode_q  <= pmode_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
      trs_q    <= trs_d;
      row_id_q <= row_id_d;
      clr_q    <= state_d == ST_CLEAR;
      ag_q     <= state_d == ST_ISSUE;
      fetch_q  <= state_d == ST_FETCH;
      stream_q <= state_d == ST_STREAM;
      busy_q   <= state_d != ST_IDLE;
      done_q   <= state_d == ST_DONE;
    end
  assign o_reg_clear   = clr_q;
  assign o_ag_en       = ag_q;
  assign o_row_id      = row_id_q;
  assign o_ac_en       = fetch_q;
  assign o_tr_en       = fetch_q;
  // stall must gate popping in the same cycle, so only this enable is combinational on an input
  assign o_miso_pop_en = stream_q & ~i_stall;
  assign o_p_mode      = pmode_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = err_q;
  assign o_state       = state_q;
endmodule

// File: tb/tb_input_router_ctrl.sv
// tb_input_router_ctrl: scoreboard bench for input_router_ctrl with directed vectors
module tb_input_router_ctrl;
  import input_router_pkg::*;
  localparam int ROWS = 4;
  localparam logic [1:0] EV_CLR = 2'd0, EV_AG = 2'd1, EV_DONE = 2'd2;
  logic clk = 1'b0;
  logic i_nrst, i_start, i_abort, i_tr_done, i_addr_empty, i_data_empty, i_stall;
  logic [1:0] i_p_mode;
  logic [2:0] i_num_rows;
  logic i_ag_valid = 1'b0;
  logic o_reg_clear, o_ag_en, o_ac_en, o_tr_en, o_miso_pop_en, o_busy, o_done, o_error;
  logic [ROWS-1:0] o_row_id;
  logic [1:0] o_p_mode;
  logic [2:0] o_state;
  logic [16:0] outs;
  int total = 0;
  int bad = 0;
  int drop_row = -1;
  logic [9:0] exp_q[$];
  always #5 clk = ~clk;
  input_router_ctrl #(.ROWS(ROWS), .CNT_W(16), .AG_TIMEOUT(64)) dut (
    .i_clk(clk), .i_nrst(i_nrst), .i_start(i_start), .i_abort(i_abort),
    .i_p_mode(i_p_mode), .i_num_rows(i_num_rows), .i_ag_valid(i_ag_valid),
    .i_tr_done(i_tr_done), .i_addr_empty(i_addr_empty), .i_data_empty(i_data_empty),
    .i_stall(i_stall), .o_reg_clear(o_reg_clear), .o_ag_en(o_ag_en), .o_row_id(o_row_id),
    .o_ac_en(o_ac_en), .o_tr_en(o_tr_en), .o_miso_pop_en(o_miso_pop_en), .o_p_mode(o_p_mode),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_state(o_state)
  );
  assign outs = {o_reg_clear, o_ag_en, o_row_id, o_ac_en, o_tr_en, o_miso_pop_en,
                 o_p_mode, o_busy, o_done, o_error, o_state};
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic [1:0] k, input int v);
    exp_q.push_back({k, 8'(v)});
  endtask
  task automatic observe(input logic [1:0] k, input logic [7:0] v);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_unexpected: got event %0d/%0h, required none", k, v);
    end else check("sb_event", {22'd0, k, v}, {22'd0, exp_q.pop_front()});
  endtask
  task automatic wait_state(input state_e s, input int budget, output int n);
    n = 0;
    while (o_state != s && n < budget) begin
      tick(1);
      n++;
    end
    if (o_state != s) check("wait_state_timeout", o_state, s);
  endtask
  task automatic start(input int nr, input logic [1:0] pm);
    i_num_rows = 3'(nr);
    i_p_mode   = pm;
    i_start    = 1'b1;
    tick(1);
    i_start    = 1'b0;
  endtask
  task automatic run_basic(input int nr, input int exp_n);
    int n;
    push(EV_CLR, 0);
    for (int k = 0; k < exp_n; k++) push(EV_AG, k);
    push(EV_DONE, 0);
    start(nr, 2'd1);
    check("basic_err_clr", o_error, 0);
    check("basic_pmode", o_p_mode, 1);
    wait_state(ST_FETCH, 40, n);
    check("basic_load_cycles", n, 1 + 2 * exp_n);
    i_tr_done = 1'b1;
    i_addr_empty = 1'b1;
    i_data_empty = 1'b1;
    tick(1);
    i_tr_done = 1'b0;
    i_addr_empty = 1'b0;
    wait_state(ST_DONE, 20, n);
    check("basic_dwell", n, ROWS + 1);
    tick(1);
    i_data_empty = 1'b0;
    check("basic_idle", o_busy, 0);
  endtask
  always begin
    @(negedge clk);
    if (o_ag_en && int'(o_row_id) != drop_row) begin
      @(posedge clk);
      #1 i_ag_valid = 1'b1;
      @(posedge clk);
      #1 i_ag_valid = 1'b0;
    end
  end
  always @(negedge clk)
    if (i_nrst) begin
      if (o_reg_clear) observe(EV_CLR, 8'd0);
      if (o_ag_en) observe(EV_AG, {4'd0, o_row_id});
      if (o_done) observe(EV_DONE, {7'd0, o_error});
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    i_nrst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_p_mode = 2'd0; i_num_rows = 3'd0;
    i_tr_done = 1'b0; i_addr_empty = 1'b0; i_data_empty = 1'b0; i_stall = 1'b0;
    tick(3);
    check("reset_outputs", outs, 0);
    i_nrst = 1'b1;
    tick(2);
    check("idle_state", o_state, ST_IDLE);
    i_start = 1'b1;
    i_abort = 1'b1;
    tick(1);
    i_start = 1'b0;
    i_abort = 1'b0;
    check("start_abort_ignored", {o_state, o_busy}, {ST_IDLE, 1'b0});
    push(EV_CLR, 0);
    for (int k = 0; k < 4; k++) push(EV_AG, k);
    push(EV_DONE, 0);
    start(4, 2'd2);
    check("nom_clear_state", o_state, ST_CLEAR);
    check("nom_pmode", o_p_mode, 2);
    wait_state(ST_FETCH, 40, n);
    check("nom_load_cycles", n, 9);
    check("nom_fetch_en", {o_ac_en, o_tr_en, o_miso_pop_en}, 3'b110);
    i_tr_done = 1'b1;
    i_addr_empty = 1'b1;
    tick(1);
    i_tr_done = 1'b0;
    i_addr_empty = 1'b0;
    check("nom_stream", o_state, ST_STREAM);
    check("nom_pop", o_miso_pop_en, 1);
    tick(1);
    i_data_empty = 1'b1;
    wait_state(ST_DONE, 20, n);
    check("nom_dwell_exit", n, 4);
    check("nom_done", {o_done, o_busy, o_error}, 3'b110);
    tick(1);
    i_data_empty = 1'b0;
    check("nom_idle", {o_busy, o_done, o_state}, 0);
    check("row_id_hold", o_row_id, 3);
    run_basic(2, 2);
    run_basic(0, 4);
    drop_row = 1;
    push(EV_CLR, 0); push(EV_AG, 0); push(EV_AG, 1); push(EV_DONE, 1);
    start(4, 2'd0);
    n = 0;
    while (!(o_state == ST_WAIT && o_row_id == 1) && n < 20) begin
      tick(1);
      n++;
    end
    check("to_reach_row1", {o_state, o_row_id}, {ST_WAIT, 4'd1});
    wait_state(ST_DONE, 100, n);
    check("to_cycles", n, 64);
    check("to_flags", {o_done, o_error}, 2'b11);
    tick(1);
    check("to_sticky", {o_state, o_error}, {ST_IDLE, 1'b1});
    drop_row = -1;
    run_basic(4, 4);
    push(EV_CLR, 0); push(EV_AG, 0); push(EV_DONE, 0);
    start(1, 2'd0);
    wait_state(ST_FETCH, 20, n);
    i_addr_empty = 1'b1;
    tick(10);
    check("fetch_addr_only_holds", o_state, ST_FETCH);
    i_tr_done = 1'b1;
    tick(1);
    i_tr_done = 1'b0;
    check("fetch_late_tr", o_state, ST_STREAM);
    i_addr_empty = 1'b0;
    i_data_empty = 1'b1;
    wait_state(ST_DONE, 20, n);
    tick(1);
    i_data_empty = 1'b0;
    push(EV_CLR, 0); push(EV_AG, 0); push(EV_DONE, 0);
    start(1, 2'd0);
    wait_state(ST_FETCH, 20, n);
    i_tr_done = 1'b1;
    tick(1);
    i_tr_done = 1'b0;
    tick(3);
    check("fetch_tr_first_holds", o_state, ST_FETCH);
    i_addr_empty = 1'b1;
    tick(1);
    check("fetch_tr_remembered", o_state, ST_STREAM);
    i_addr_empty = 1'b0;
    i_data_empty = 1'b1;
    wait_state(ST_DONE, 20, n);
    tick(1);
    i_data_empty = 1'b0;
    push(EV_CLR, 0); push(EV_AG, 0); push(EV_DONE, 0);
    start(1, 2'd0);
    wait_state(ST_FETCH, 20, n);
    i_tr_done = 1'b1;
    i_addr_empty = 1'b1;
    i_data_empty = 1'b1;
    tick(1);
    i_tr_done = 1'b0;
    i_addr_empty = 1'b0;
    check("stall_stream", o_state, ST_STREAM);
    tick(1);
    i_stall = 1'b1;
    #1;
    check("stall_pop_low", {o_miso_pop_en, o_state}, {1'b0, ST_STREAM});
    tick(3);
    i_stall = 1'b0;
    #1;
    check("stall_pop_back", o_miso_pop_en, 1);
    wait_state(ST_DONE, 20, n);
    check("stall_exit_delay", n, 4);
    tick(1);
    i_data_empty = 1'b0;
    push(EV_CLR, 0); push(EV_CLR, 0);
    start(4, 2'd0);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    check("abort_clear_restart", {o_state, o_reg_clear}, {ST_CLEAR, 1'b1});
    tick(1);
    check("abort_clear_idle", {o_state, o_done, o_busy}, 0);
    drop_row = 0;
    push(EV_CLR, 0); push(EV_AG, 0); push(EV_CLR, 0);
    start(4, 2'd0);
    wait_state(ST_WAIT, 10, n);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    check("abort_wait_clear", {o_state, o_reg_clear}, {ST_CLEAR, 1'b1});
    tick(1);
    check("abort_wait_idle", {o_state, o_done, o_busy}, 0);
    drop_row = -1;
    push(EV_CLR, 0); push(EV_AG, 0); push(EV_CLR, 0);
    start(1, 2'd0);
    wait_state(ST_FETCH, 20, n);
    i_tr_done = 1'b1;
    i_addr_empty = 1'b1;
    tick(1);
    i_tr_done = 1'b0;
    i_addr_empty = 1'b0;
    tick(2);
    check("abort_stream_pre", o_state, ST_STREAM);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    check("abort_stream_clear", {o_state, o_reg_clear, o_miso_pop_en}, {ST_CLEAR, 2'b10});
    tick(1);
    check("abort_stream_idle", {o_state, o_done, o_busy}, 0);
    push(EV_CLR, 0); push(EV_AG, 0);
    start(1, 2'd3);
    wait_state(ST_FETCH, 20, n);
    check("pre_reset_fetch", {o_ac_en, o_tr_en, o_p_mode}, 4'b1111);
    #2 i_nrst = 1'b0;
    #1 check("async_reset", outs, 0);
    @(posedge clk);
    #1 i_nrst = 1'b1;
    tick(2);
    check("post_reset_idle", outs, 0);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/input_router_ctrl.md
Name: input_router_ctrl

Overview:
- Sequencer for one input-router row group: clears it, loads per-row address lists via the address generator, runs address compare against the tile reader stream, then drains the row MISO FIFOs into the array.
- Sits between the layer controller (start/abort/config) and the row group, address generator and tile reader.
- Pure control; no data path.

Parameters:
ROWS, 4, number of row routers in the group
CNT_W, 16, width of the dwell and timeout counters
AG_TIMEOUT, 64, maximum cycles to wait for an address-generator response

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_start  in  1  one-cycle start pulse; ignored unless the block is idle
i_abort  in  1  abort request; honoured in any state
i_p_mode  in  2  precision mode, latched on start
i_num_rows  in  $clog2(ROWS+1)  active rows for this tile, 1..ROWS; 0 is treated as ROWS
i_ag_valid  in  1  address-generator response, 1 cycle after o_ag_en
i_tr_done  in  1  tile reader finished streaming; may be a pulse
i_addr_empty  in  1  row-group MPP-empty flag (all address/data fetched)
i_data_empty  in  1  row-group MISO-empty flag
i_stall  in  1  downstream backpressure; gates popping
o_reg_clear  out  1  row-group register clear
o_ag_en  out  1  address-generator enable, one cycle per row
o_row_id  out  ROWS  row index presented with each address-generator request
o_ac_en  out  1  address-comparator enable
o_tr_en  out  1  tile-reader run enable
o_miso_pop_en  out  1  row-group pop enable
o_p_mode  out  2  latched precision mode
o_busy  out  1  high whenever the state is not IDLE
o_done  out  1  one-cycle completion pulse
o_error  out  1  sticky address-generator timeout flag; cleared on the next accepted start
o_state  out  3  current state encoding, for debug

Behaviour:
- Reset: state IDLE. All outputs 0, including o_row_id, o_p_mode and all counters.
- All outputs are registered decodes of the state and counters.
- States: IDLE, CLEAR, ISSUE, WAIT, FETCH, STREAM, DONE.
- IDLE:
  - On i_start (and no i_abort): latch i_p_mode and i_num_rows, clear o_error, row counter r=0, go to CLEAR.
  - A start that coincides with an abort is ignored.
- CLEAR: o_reg_clear=1 for exactly 1 cycle, then ISSUE.
- ISSUE: o_ag_en=1 and o_row_id=r for 1 cycle, then WAIT. o_row_id holds r until the next ISSUE.
- WAIT:
  - Count cycles. If i_ag_valid: when r==num_rows-1 go to FETCH, else r++ and go to ISSUE.
  - If the count reaches AG_TIMEOUT with no i_ag_valid: set o_error and go to DONE.
  - i_ag_valid outside WAIT is ignored.
- FETCH:
  - o_ac_en=1 and o_tr_en=1.
  - A sticky tr_seen flag is set by i_tr_done, including an i_tr_done on the FETCH entry cycle.
  - Exit to STREAM when tr_seen and i_addr_empty are both high in the same cycle. i_addr_empty alone never exits, because the flags read empty right after a clear.
- STREAM:
  - o_miso_pop_en = ~i_stall.
  - A dwell counter counts unstalled cycles.
  - Exit to DONE when i_data_empty is high, dwell >= ROWS+1 (the row group staggers pop enables one row per cycle), and i_stall is low.
  - If stall is asserted, popping and the dwell counter hold.
- DONE: o_done=1 for 1 cycle, then IDLE. o_done is also asserted on the timeout path.
- i_abort:
  - In any non-IDLE state, go to CLEAR with an abort flag set. CLEAR then goes to IDLE with no o_done.
  - Abort in IDLE: no effect.
  - Abort during CLEAR restarts the 1-cycle clear.
- Counters saturate and never wrap.
- The row counter width is $clog2(ROWS); it is zero-extended onto o_row_id.
- Asynchronous reset mid-operation returns to IDLE immediately with all outputs 0.

Decomposition:
- Shared package input_router_pkg:
  - state enum (3-bit encoding, exported on o_state)
  - PMODE encodings
  - row-count width function
- One natural sub-module: sat_counter (enable, clear, saturate-at-max). Instantiated for the timeout and dwell counters.

Test Plan:
- Nominal, ROWS=4, num_rows=4: start -> 1 clear pulse, 4 ag_en pulses with row_id 0,1,2,3, each valid returned 1 cycle later; tr_done plus addr_empty -> STREAM; data_empty on dwell cycle 2 -> exit waits until dwell 5; then 1-cycle o_done and busy=0.
- num_rows=2 and num_rows=0: exactly 2 and 4 ag_en pulses respectively; row_id never exceeds num_rows-1.
- Address-generator timeout: drop valid for row 1 -> after 64 WAIT cycles o_error=1 and o_done pulses. A following start clears o_error.
- FETCH ordering: addr_empty high from entry with tr_done arriving 10 cycles later -> STREAM entered the cycle after tr_done. Separately, a tr_done pulse before addr_empty is remembered.
- Stall: i_stall high for 3 cycles mid-STREAM -> pop_en low for those cycles and dwell frozen; exit is delayed by 3 cycles.
- Abort in WAIT and in STREAM -> one reg_clear, then IDLE with no o_done. Separately, async reset during FETCH -> all outputs 0 immediately.
